// File: rtl/score_pkg.sv
// Shared types and constants for the score sequencer: FSM states, event weights
// and the default BCD thresholds.
package score_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PULSE  = 2'd1,
      SETTLE = 2'd2
   } score_state_t;

   localparam int W_PELLET     = 1;
   localparam int W_POWER      = 5;
   localparam int W_GHOST_BASE = 20;
   localparam int W_FRUIT      = 10;

   // Largest single-cycle event sum is 1 + 5 + 160 + 10 = 176.
   localparam int EVT_W = 8;

   localparam logic [15:0] SCORE_MAX_DEFAULT     = 16'h0999;
   localparam logic [15:0] EXTRA_LIFE_AT_DEFAULT = 16'h0500;

   function automatic logic [EVT_W-1:0] ghost_weight(input logic [1:0] combo);
      return EVT_W'(W_GHOST_BASE) << combo;
   endfunction

   // The score register spends one cycle on each digit that has reached A.
   function automatic logic bcd_correcting(input logic [15:0] score);
      return (score[3:0] == 4'hA) || (score[7:4] == 4'hA);
   endfunction

endpackage

// File: rtl/score_pending_acc.sv
// Saturating accumulator of owed score increments: adds the event weight,
// subtracts one per issued pulse, never underflows, clears synchronously.
module score_pending_acc #(
   parameter int PEND_W = 10,
   parameter int ADD_W  = 8
) (
   input  logic              Clk,
   input  logic              i_clr,
   input  logic [ADD_W-1:0]  i_add,
   input  logic              i_dec,
   output logic [PEND_W-1:0] o_value,
   output logic [PEND_W-1:0] o_next
);

   localparam int SUM_W = ((PEND_W > ADD_W) ? PEND_W : ADD_W) + 1;

   logic [PEND_W-1:0] r_value;
   logic [SUM_W-1:0]  w_sum;
   logic [SUM_W-1:0]  w_max;
   logic [PEND_W-1:0] w_next;

   always_comb begin
      w_max = SUM_W'({PEND_W{1'b1}});
      w_sum = SUM_W'(r_value) + SUM_W'(i_add);
      if (i_dec && (w_sum != '0)) begin
         w_sum = w_sum - SUM_W'(1);
      end
      if (i_clr) begin
         w_next = '0;
      end else if (w_sum > w_max) begin
         w_next = '1;
      end else begin
         w_next = w_sum[PEND_W-1:0];
      end
   end

   always_ff @(posedge Clk) begin
      r_value <= w_next;
   end

   assign o_value = r_value;
   assign o_next  = w_next;

endmodule

// File: rtl/score_sequencer.sv
// Turns scoring events into paced single-cycle increment pulses for the BCD
// score register; also tracks ghost combo, saturation and the extra life.
module score_sequencer
   import score_pkg::*;
#(
   parameter int          PEND_W        = 10,
   parameter logic [15:0] EXTRA_LIFE_AT = EXTRA_LIFE_AT_DEFAULT,
   parameter logic [15:0] SCORE_MAX     = SCORE_MAX_DEFAULT
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Reset_game,
   input  logic              pellet_eaten,
   input  logic              power_eaten,
   input  logic              ghost_eaten,
   input  logic              fruit_eaten,
   input  logic [15:0]       score_in,
   output logic              increment,
   output logic              busy,
   output logic              extra_life,
   output logic [1:0]        ghost_combo,
   output score_state_t      o_dbg_state,
   output logic [PEND_W-1:0] o_dbg_pending
);

   // Handshake: none. Events are one-cycle strobes, always accepted unless the
   // score is full or a reset is active; increment is a one-cycle strobe the
   // score register must accept unconditionally.

   score_state_t      r_state;
   logic              r_increment;
   logic [1:0]        r_combo;
   logic              r_life_given;
   logic              r_extra_life;

   logic              w_clear;
   logic              w_full;
   logic              w_go;
   logic [EVT_W-1:0]  w_add;
   logic [PEND_W-1:0] w_pending;
   logic [PEND_W-1:0] w_pending_next;

   assign w_clear = Reset | Reset_game;
   assign w_full  = (score_in >= SCORE_MAX);

   always_comb begin
      w_add = '0;
      if (pellet_eaten) w_add = w_add + EVT_W'(W_PELLET);
      if (power_eaten)  w_add = w_add + EVT_W'(W_POWER);
      if (ghost_eaten)  w_add = w_add + ghost_weight(r_combo);
      if (fruit_eaten)  w_add = w_add + EVT_W'(W_FRUIT);
   end

   // Clearing on full also discards any events arriving in that cycle.
   score_pending_acc #(
      .PEND_W (PEND_W),
      .ADD_W  (EVT_W)
   ) u_acc (
      .Clk     (Clk),
      .i_clr   (w_clear | w_full),
      .i_add   (w_add),
      .i_dec   (r_increment),
      .o_value (w_pending),
      .o_next  (w_pending_next)
   );

   // Deciding on the next accumulator value lets a pulse follow its event
   // by a single cycle.
   assign w_go = (w_pending_next != '0) && !w_full;

   always_ff @(posedge Clk) begin
      if (w_clear) begin
         r_state     <= IDLE;
         r_increment <= 1'b0;
      end else begin
         r_increment <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_go) begin
                  r_state     <= PULSE;
                  r_increment <= 1'b1;
               end
            end
            PULSE: begin
               r_state <= SETTLE;
            end
            SETTLE: begin
               if (bcd_correcting(score_in)) begin
                  r_state <= SETTLE;
               end else if (w_go) begin
                  r_state     <= PULSE;
                  r_increment <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // A ghost is scored at the old index; power then wins the index update.
   always_ff @(posedge Clk) begin
      if (w_clear) begin
         r_combo <= 2'd0;
      end else if (!w_full) begin
         if (power_eaten) begin
            r_combo <= 2'd0;
         end else if (ghost_eaten && (r_combo != 2'd3)) begin
            r_combo <= r_combo + 2'd1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (w_clear) begin
         r_life_given <= 1'b0;
         r_extra_life <= 1'b0;
      end else begin
         r_extra_life <= 1'b0;
         if ((score_in >= EXTRA_LIFE_AT) && !r_life_given) begin
            r_extra_life <= 1'b1;
            r_life_given <= 1'b1;
         end
      end
   end

   assign increment     = r_increment;
   assign busy          = (r_state != IDLE) || (w_pending != '0);
   assign extra_life    = r_extra_life;
   assign ghost_combo   = r_combo;
   assign o_dbg_state   = r_state;
   assign o_dbg_pending = w_pending;

endmodule

// File: doc/score_sequencer.md
# score_sequencer

Converts gameplay scoring events (pellet, power pellet, ghost, fruit) into single-cycle `increment` pulses for the BCD score register, paced so no pulse lands on a BCD-correction cycle. Sits between the game-logic FSM and the score register and reads back the register's `out` value. Also tracks the ghost-combo multiplier, score saturation and the one-time extra-life award. One increment equals 10 displayed points; the trailing zero is drawn by the sprite ROM.

## Interface
- `PEND_W`, default 10: width of the pending-increment accumulator.
- `EXTRA_LIFE_AT`, default 16'h0500: BCD score threshold for the extra life (5000 points).
- `SCORE_MAX`, default 16'h0999: BCD saturation value (9990 points).
- `Clk` in 1: system clock. Reset is `Reset`, synchronous, active-high; the clock is `Clk`.
- `Reset` in 1: synchronous, active-high global reset.
- `Reset_game` in 1: synchronous, active-high new-game clear; same effect as `Reset`.
- `pellet_eaten` in 1: one-cycle event; weight 1.
- `power_eaten` in 1: one-cycle event; weight 5; restarts the ghost combo.
- `ghost_eaten` in 1: one-cycle event; weight 20/40/80/160 by combo index.
- `fruit_eaten` in 1: one-cycle event; weight 10.
- `score_in` in 16: BCD score fed back from the score register output.
- `increment` out 1: increment pulse to the score register.
- `busy` out 1: high while the accumulator is non-zero or the FSM is not in IDLE.
- `extra_life` out 1: one-cycle pulse, issued at most once per game.
- `ghost_combo` out 2: current combo index, 0..3.

## Operation
- **Accumulator**
  - `pending` is PEND_W bits wide.
  - Each cycle it adds the sum of the weights of all asserted events and subtracts 1 when `increment` is high.
  - The result saturates at 2^PEND_W−1 and never underflows.
  - Simultaneous events are summed in the same cycle.
- **Ghost combo**
  - Weight is `20 << ghost_combo`.
  - After each ghost event the index increments, saturating at 3.
  - `power_eaten` clears the index to 0.
  - If `power_eaten` and `ghost_eaten` arrive in the same cycle, the ghost is scored at the old index and the index is then cleared to 0.
- **FSM states:** IDLE, PULSE, SETTLE.
  - IDLE → PULSE when `pending`≠0 and not full.
  - PULSE drives `increment`=1 for exactly one cycle, then goes to SETTLE.
  - SETTLE stays while `score_in[3:0]`==4'hA or `score_in[7:4]`==4'hA, because a correction is in progress and a pulse would be lost.
  - Otherwise SETTLE → PULSE if `pending`≠0 and not full, else → IDLE.
- **Full:** `score_in` ≥ SCORE_MAX.
  - When full, no further pulses are issued and `pending` is cleared to 0.
  - Events arriving while full are discarded.
- **Extra life**
  - The `life_given` flag starts at 0.
  - The first cycle with `score_in` ≥ EXTRA_LIFE_AT and `life_given`=0 pulses `extra_life` and sets `life_given`.
  - BCD values are compared as binary; this is valid because BCD is monotonic.
- **Reset / Reset_game**
  - State IDLE, `pending`=0, `ghost_combo`=0, `life_given`=0.
  - All outputs 0: `increment`=0, `busy`=0, `extra_life`=0, `ghost_combo`=0.
  - Events in a reset cycle are discarded.
  - Reset asserted mid-PULSE aborts the pulse on the next cycle.

## Timing
- `increment` is decoded from the registered state, so it is glitch-free.
- Event at edge N updates `pending` at N+1. The earliest pulse is cycle N+1 in state PULSE.
- Throughput: 1 increment per 2 cycles, plus 1 cycle per BCD digit correction.
- `busy` falls the cycle the FSM returns to IDLE with `pending`=0.
- `extra_life` rises 1 cycle after `score_in` crosses the threshold.

## Structure
- Package `score_pkg` holds:
  - the `score_state_t` enum (IDLE, PULSE, SETTLE);
  - weight constants `W_PELLET`=1, `W_POWER`=5, `W_GHOST_BASE`=20, `W_FRUIT`=10;
  - default values for SCORE_MAX and EXTRA_LIFE_AT.
- One sub-module, `score_pending_acc`: a saturating add/subtract accumulator with a synchronous clear.
- The FSM, combo counter and extra-life logic live in the top level.

## Test plan
- **Single pellet:** score 0, one `pellet_eaten` → exactly one `increment`; `score_in` becomes 16'h0001; `busy` low 3 cycles after the event.
- **BCD carry:** score 16'h0009, `power_eaten` → 5 pulses, none during the 16'h000A cycle; final score 16'h0014.
- **Ghost combo:** `power_eaten`, then 4 ghosts → weights 20, 40, 80, 160; final `ghost_combo`=3; total +305 increments. A fifth ghost adds 160.
- **Simultaneous events:** `pellet_eaten`, `fruit_eaten` and `ghost_eaten` (combo 0) in the same cycle → `pending`=31 next cycle; 31 pulses total.
- **Thresholds:**
  - Score 16'h0499 plus 2 pellets → `extra_life` pulses once at 16'h0500 and does not pulse again at 16'h0501.
  - Score 16'h0998 plus a fruit → stops at 16'h0999 and `pending` is cleared.
- **Reset mid-stream:** `Reset_game` while `pending`=12 in PULSE → next cycle `increment`=0, `pending`=0, IDLE, `ghost_combo`=0; an event in the reset cycle is ignored.
